// File: rtl/rv_adcseq_if.sv
// rv_adcseq_if: rv_core data-bus port of the XADC DRP sequencer.
// master = bus side (core / testbench), slave = rv_adcseq.
interface rv_adcseq_if;
  logic [6:0]  adr;
  logic        cs;
  logic        rdy;
  logic [3:0]  we;
  logic        re;
  logic [31:0] dw;
  logic [31:0] dr;

  modport master (output adr, cs, rdy, we, re, dw, input dr);
  modport slave  (input adr, cs, rdy, we, re, dw, output dr);
endinterface

// File: rtl/rv_adcseq.sv
// rv_adcseq: bus-mapped sequencer that polls NCH XADC channels round-robin
// over DRP, averages 2**AVG_LOG2 scans per channel, keeps the latest raw
// sample, raises sticky hi/lo threshold alarms with a maskable level irq and
// exports the averaged channel-0 value as device_temp.
// Optional build macro RV_ADCSEQ_MINMAX_EN adds per-channel min/max tracking
// of the averaged values (words 24+i, re-armed by writing CTRL[1]=1).
module rv_adcseq #(
  parameter int               NCH      = 7,
  parameter logic [5*NCH-1:0] CH_ADDR  = {5'h1a, 5'h19, 5'h15, 5'h14, 5'h12, 5'h11, 5'h00},
  parameter int               AVG_LOG2 = 2,
  parameter int               TIMEOUT  = 63
) (
  input  logic              clk,
  input  logic              xreset,
  rv_adcseq_if.slave        bus,
  output logic              drp_den,
  output logic [6:0]        drp_daddr,
  input  logic              drp_drdy,
  input  logic [15:0]       drp_do,
  output logic [11:0]       device_temp,
  output logic              irq
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = 12 + AVG_LOG2;
  localparam int SW = AVG_LOG2 + 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(NCH - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'((1 << AVG_LOG2) - 1);
  localparam logic [15:0]   TMO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACC  = 3'd3,
    ST_NEXT = 3'd4
  } state_e;

  // DRP address of channel slot i: upper two address bits are always zero.
  function automatic logic [6:0] ch_daddr(input logic [IW-1:0] i);
    return {2'b00, CH_ADDR[5*int'(i) +: 5]};
  endfunction

  state_e        state_q, state_d;
  logic          enable_q, enable_d;
  logic [15:0]   mask_q, mask_d;
  logic [11:0]   lo_q, lo_d;
  logic [11:0]   hi_q, hi_d;
  logic          tmo_q, tmo_d;
  logic [15:0]   alarm_q, alarm_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic [11:0]   raw_q [NCH];
  logic [11:0]   raw_d [NCH];
  logic [AW-1:0] acc_q [NCH];
  logic [AW-1:0] acc_d [NCH];
  logic [11:0]   avg_q [NCH];
  logic [11:0]   avg_d [NCH];
  logic [31:0]   dr_q, dr_d;
  logic          den_q, den_d;
  logic [6:0]    daddr_q, daddr_d;
  logic [11:0]   temp_q, temp_d;
  logic          irq_q, irq_d;
`ifdef RV_ADCSEQ_MINMAX_EN
  logic [11:0]   mn_q [NCH];
  logic [11:0]   mn_d [NCH];
  logic [11:0]   mx_q [NCH];
  logic [11:0]   mx_d [NCH];
`endif

  logic [4:0]    widx_s;
  logic          wr_s, wr_ctrl_s, wr_stat_s, wr_thr_s;
  logic          tmo_clr_s, tmo_set_s, rearm_s, upd_s, busy_s;
  logic [15:0]   alm_clr_s, alm_set_s;
  logic [11:0]   avg_new_s [NCH];
  logic [31:0]   rd_word_s;
  logic          unused_s;

  assign widx_s    = bus.adr[6:2];
  assign wr_s      = bus.cs && bus.rdy && (bus.we != 4'b0000);
  assign wr_ctrl_s = wr_s && (widx_s == 5'd0);
  assign wr_stat_s = wr_s && (widx_s == 5'd1);
  assign wr_thr_s  = wr_s && (widx_s == 5'd2);
  assign tmo_clr_s = wr_stat_s && bus.we[0] && bus.dw[1];
  assign alm_clr_s = {(wr_stat_s && bus.we[3]) ? bus.dw[31:24] : 8'h00,
                      (wr_stat_s && bus.we[2]) ? bus.dw[23:16] : 8'h00};
  assign rearm_s   = wr_ctrl_s && bus.we[0] && bus.dw[1];
  assign busy_s    = (state_q != ST_IDLE);
  assign upd_s     = (state_q == ST_NEXT) && (idx_q == IDX_LAST) && (scan_q == SCAN_LAST);
  assign unused_s  = ^{drp_do[3:0], bus.dw[15:12], bus.adr[1:0], rearm_s};

  // Candidate averages: accumulator divided by the scan count (upper 12 bits).
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      avg_new_s[i] = acc_q[i][AW-1 -: 12];
    end
  end

  // Register-file read multiplexer for the addressed word.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    case (widx_s)
      5'd0:    rd_word_s = {mask_q, 15'h0000, enable_q};
      5'd1:    rd_word_s = {alarm_q, 14'h0000, tmo_q, busy_s};
      5'd2:    rd_word_s = {4'h0, hi_q, 4'h0, lo_q};
      default: rd_word_s = 32'h0000_0000;
    endcase
    for (int i = 0; i < NCH; i++) begin
      rd_word_s = (widx_s == 5'(8 + i)) ? {4'h0, raw_q[i], 4'h0, avg_q[i]} : rd_word_s;
`ifdef RV_ADCSEQ_MINMAX_EN
      rd_word_s = ((24 + i < 32) && (widx_s == 5'(24 + i))) ? {4'h0, mx_q[i], 4'h0, mn_q[i]}
                                                             : rd_word_s;
`endif
    end
  end

  // Next-state logic: bus writes, polling FSM, averaging, alarms and outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    scan_d    = scan_q;
    wcnt_d    = wcnt_q;
    raw_d     = raw_q;
    acc_d     = acc_q;
    avg_d     = avg_q;
    den_d     = 1'b0;
    daddr_d   = daddr_q;
    temp_d    = temp_q;
    tmo_set_s = 1'b0;
    alm_set_s = 16'h0000;
`ifdef RV_ADCSEQ_MINMAX_EN
    mn_d      = mn_q;
    mx_d      = mx_q;
`endif

    enable_d      = (wr_ctrl_s && bus.we[0]) ? bus.dw[0]     : enable_q;
    mask_d[7:0]   = (wr_ctrl_s && bus.we[2]) ? bus.dw[23:16] : mask_q[7:0];
    mask_d[15:8]  = (wr_ctrl_s && bus.we[3]) ? bus.dw[31:24] : mask_q[15:8];
    lo_d[7:0]     = (wr_thr_s && bus.we[0])  ? bus.dw[7:0]   : lo_q[7:0];
    lo_d[11:8]    = (wr_thr_s && bus.we[1])  ? bus.dw[11:8]  : lo_q[11:8];
    hi_d[7:0]     = (wr_thr_s && bus.we[2])  ? bus.dw[23:16] : hi_q[7:0];
    hi_d[11:8]    = (wr_thr_s && bus.we[3])  ? bus.dw[27:24] : hi_q[11:8];

    case (state_q)
      ST_IDLE: begin
        if (enable_q) begin
          state_d = ST_REQ;
          idx_d   = {IW{1'b0}};
          den_d   = 1'b1;
          daddr_d = ch_daddr({IW{1'b0}});
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        wcnt_d  = 16'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (drp_drdy) begin
          raw_d[idx_q] = drp_do[15:4];
          state_d      = ST_ACC;
        end else if (wcnt_q == TMO_LAST) begin
          // No answer: keep the previous raw sample for this channel.
          tmo_set_s = 1'b1;
          state_d   = ST_ACC;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      ST_ACC: begin
        acc_d[idx_q] = acc_q[idx_q] + AW'(raw_q[idx_q]);
        state_d      = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q == IDX_LAST) begin
          idx_d  = {IW{1'b0}};
          scan_d = (scan_q == SCAN_LAST) ? {SW{1'b0}} : scan_q + 1'b1;
        end else begin
          idx_d  = idx_q + 1'b1;
        end
        for (int i = 0; i < NCH; i++) begin
          avg_d[i]     = upd_s ? avg_new_s[i] : avg_q[i];
          acc_d[i]     = upd_s ? {AW{1'b0}} : acc_q[i];
          alm_set_s[i] = upd_s && ((avg_new_s[i] > hi_q) || (avg_new_s[i] < lo_q));
`ifdef RV_ADCSEQ_MINMAX_EN
          mn_d[i] = (upd_s && (avg_new_s[i] < mn_q[i])) ? avg_new_s[i] : mn_q[i];
          mx_d[i] = (upd_s && (avg_new_s[i] > mx_q[i])) ? avg_new_s[i] : mx_q[i];
`endif
        end
        temp_d = upd_s ? avg_new_s[0] : temp_q;
        if (enable_q) begin
          state_d = ST_REQ;
          den_d   = 1'b1;
          daddr_d = ch_daddr(idx_d);
        end else begin
          // Stopping: partial scan data is discarded, averages/raw kept.
          state_d = ST_IDLE;
          idx_d   = {IW{1'b0}};
          scan_d  = {SW{1'b0}};
          for (int i = 0; i < NCH; i++) begin
            acc_d[i] = {AW{1'b0}};
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef RV_ADCSEQ_MINMAX_EN
    for (int i = 0; i < NCH; i++) begin
      mn_d[i] = rearm_s ? 12'hfff : mn_d[i];
      mx_d[i] = rearm_s ? 12'h000 : mx_d[i];
    end
`endif

    // Sticky flags: a set in the same cycle as a W1C clear wins.
    tmo_d   = (tmo_q && !tmo_clr_s) || tmo_set_s;
    alarm_d = (alarm_q & ~alm_clr_s) | alm_set_s;
    irq_d   = |(alarm_q & mask_q);
    dr_d    = bus.rdy ? ((bus.cs && bus.re) ? rd_word_s : 32'h0000_0000) : dr_q;
  end

  // State and register flops with asynchronous active-low reset.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
      mask_q   <= 16'h0000;
      lo_q     <= 12'h000;
      hi_q     <= 12'hfff;
      tmo_q    <= 1'b0;
      alarm_q  <= 16'h0000;
      idx_q    <= {IW{1'b0}};
      scan_q   <= {SW{1'b0}};
      wcnt_q   <= 16'd0;
      dr_q     <= 32'h0000_0000;
      den_q    <= 1'b0;
      daddr_q  <= 7'h00;
      temp_q   <= 12'h000;
      irq_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        raw_q[i] <= 12'h000;
        acc_q[i] <= {AW{1'b0}};
        avg_q[i] <= 12'h000;
`ifdef RV_ADCSEQ_MINMAX_EN
        mn_q[i]  <= 12'hfff;
        mx_q[i]  <= 12'h000;
`endif
      end
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      mask_q   <= mask_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      tmo_q    <= tmo_d;
      alarm_q  <= alarm_d;
      idx_q    <= idx_d;
      scan_q   <= scan_d;
      wcnt_q   <= wcnt_d;
      dr_q     <= dr_d;
      den_q    <= den_d;
      daddr_q  <= daddr_d;
      temp_q   <= temp_d;
      irq_q    <= irq_d;
      raw_q    <= raw_d;
      acc_q    <= acc_d;
      avg_q    <= avg_d;
`ifdef RV_ADCSEQ_MINMAX_EN
      mn_q     <= mn_d;
      mx_q     <= mx_d;
`endif
    end
  end

  assign bus.dr      = dr_q;
  assign drp_den     = den_q;
  assign drp_daddr   = daddr_q;
  assign device_temp = temp_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_rv_adcseq.sv
// tb_rv_adcseq: scoreboard bench for rv_adcseq with a behavioural DRP slave.
module tb_rv_adcseq;
  logic        clk = 1'b0;
  logic        xreset = 1'b0;
  logic        drp_den;
  logic [6:0]  drp_daddr;
  logic        drp_drdy;
  logic [15:0] drp_do;
  logic [11:0] device_temp;
  logic        irq;

  always #5 clk = ~clk;

  rv_adcseq_if bus_if();

  rv_adcseq dut (
    .clk(clk), .xreset(xreset), .bus(bus_if),
    .drp_den(drp_den), .drp_daddr(drp_daddr), .drp_drdy(drp_drdy), .drp_do(drp_do),
    .device_temp(device_temp), .irq(irq)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [6:0]  addr_tab [7] = '{7'h00, 7'h11, 7'h12, 7'h14, 7'h15, 7'h19, 7'h1a};
  logic [6:0]  exp_addr_q [$];
  logic [31:0] exp_rd_q [$];
  logic [15:0] resp [32];
  logic [15:0] ch0_q [$];
  logic [4:0]  silent = 5'h00;
  bit          silent_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // DRP address monitor: every den pulse must match the next expected address.
  initial begin
    forever begin
      @(negedge clk);
      if (drp_den === 1'b1) begin
        if (exp_addr_q.size() == 0) check_val("den_extra", 32'(drp_den), 32'd0);
        else check_val("daddr", 32'(drp_daddr), 32'(exp_addr_q.pop_front()));
      end
    end
  end

  // DRP slave model: answers 3 cycles after den unless the channel is silenced.
  initial begin
    logic [4:0] a;
    drp_drdy = 1'b0;
    drp_do   = 16'hdead;
    forever begin
      @(negedge clk);
      if (drp_den === 1'b1 && !(silent_en && drp_daddr[4:0] == silent)) begin
        a = drp_daddr[4:0];
        repeat (3) @(negedge clk);
        drp_drdy = 1'b1;
        if (a == 5'h00 && ch0_q.size() > 0) drp_do = ch0_q.pop_front();
        else drp_do = resp[a];
        @(negedge clk);
        drp_drdy = 1'b0;
        drp_do   = 16'hdead;
      end
    end
  end

  task automatic bus_wr(input logic [4:0] w, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus_if.adr = {w, 2'b00}; bus_if.dw = d; bus_if.we = be;
    bus_if.cs = 1'b1; bus_if.re = 1'b0; bus_if.rdy = 1'b1;
    @(negedge clk);
    bus_if.cs = 1'b0; bus_if.we = 4'h0;
  endtask

  task automatic bus_rd(input string tag, input logic [4:0] w, input logic [31:0] exp);
    @(negedge clk);
    bus_if.adr = {w, 2'b00}; bus_if.we = 4'h0;
    bus_if.cs = 1'b1; bus_if.re = 1'b1; bus_if.rdy = 1'b1;
    exp_rd_q.push_back(exp);
    @(negedge clk);
    check_val(tag, bus_if.dr, exp_rd_q.pop_front());
    bus_if.cs = 1'b0; bus_if.re = 1'b0;
  endtask

  task automatic wait_addr_drain(input int budget);
    int guard = 0;
    while (exp_addr_q.size() != 0 && guard < budget) begin
      @(negedge clk);
      guard++;
    end
    check_val("scan_done", 32'(exp_addr_q.size()), 32'd0);
    exp_addr_q.delete();
  endtask

  // Run k full scans with the given alarm mask, then stop and let the FSM idle.
  task automatic run_scans(input int k, input logic [15:0] mask);
    for (int s = 0; s < k; s++)
      for (int i = 0; i < 7; i++) exp_addr_q.push_back(addr_tab[i]);
    bus_wr(5'd0, {mask, 16'h0001}, 4'hf);
    wait_addr_drain(k * 7 * 100);
    bus_wr(5'd0, {mask, 16'h0000}, 4'hf);
    repeat (100) @(negedge clk);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) resp[i] = 16'h8000;
    bus_if.adr = 7'h00; bus_if.cs = 1'b0; bus_if.rdy = 1'b0;
    bus_if.we = 4'h0; bus_if.re = 1'b0; bus_if.dw = 32'h0;
    repeat (3) @(negedge clk);
    xreset = 1'b1;
    @(negedge clk);

    // Reset state
    check_val("rst_den", 32'(drp_den), 32'd0);
    check_val("rst_daddr", 32'(drp_daddr), 32'd0);
    check_val("rst_temp", 32'(device_temp), 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_dr", bus_if.dr, 32'd0);
    bus_rd("rst_ctrl", 5'd0, 32'h0000_0000);
    bus_rd("rst_status", 5'd1, 32'h0000_0000);
    bus_rd("rst_thresh", 5'd2, 32'h0fff_0000);
    bus_rd("rst_data0", 5'd8, 32'h0000_0000);

    // Uniform 0x800 on all channels, four scans
    run_scans(4, 16'h0000);
    for (int i = 0; i < 7; i++) bus_rd($sformatf("data%0d_uni", i), 5'(8 + i), 32'h0800_0800);
    check_val("temp_uni", 32'(device_temp), 32'h800);
    bus_rd("status_uni", 5'd1, 32'h0000_0000);

    // Ramp on channel 0
    ch0_q.push_back(16'h1000); ch0_q.push_back(16'h2000);
    ch0_q.push_back(16'h3000); ch0_q.push_back(16'h4000);
    run_scans(4, 16'h0000);
    bus_rd("data0_ramp", 5'd8, 32'h0400_0280);
    bus_rd("data1_ramp", 5'd9, 32'h0800_0800);
    check_val("temp_ramp", 32'(device_temp), 32'h280);

    // High threshold alarm, irq and W1C behaviour
    bus_wr(5'd2, 32'h0700_0000, 4'hf);
    run_scans(4, 16'h0001);
    bus_rd("status_hi", 5'd1, 32'h007f_0000);
    check_val("irq_hi", 32'(irq), 32'd1);
    bus_wr(5'd1, 32'h0001_0000, 4'hf);
    check_val("irq_w1c_lat", 32'(irq), 32'd1);
    @(negedge clk);
    check_val("irq_w1c", 32'(irq), 32'd0);
    bus_rd("status_w1c", 5'd1, 32'h007e_0000);
    run_scans(4, 16'h0001);
    bus_rd("status_reset", 5'd1, 32'h007f_0000);
    check_val("irq_reset", 32'(irq), 32'd1);
    bus_wr(5'd0, 32'h0000_0000, 4'hf);
    check_val("irq_mask_lat", 32'(irq), 32'd1);
    @(negedge clk);
    check_val("irq_masked", 32'(irq), 32'd0);
    bus_wr(5'd1, 32'hffff_0000, 4'hf);
    bus_rd("status_clr", 5'd1, 32'h0000_0000);

    // Equality does not alarm; one below lo does
    bus_wr(5'd2, 32'h0800_0800, 4'hf);
    run_scans(4, 16'hffff);
    bus_rd("status_eq", 5'd1, 32'h0000_0000);
    check_val("irq_eq", 32'(irq), 32'd0);
    bus_wr(5'd2, 32'h0800_0801, 4'hf);
    run_scans(4, 16'h0000);
    bus_rd("status_lo", 5'd1, 32'h007f_0000);
    check_val("irq_lo_masked", 32'(irq), 32'd0);
    bus_wr(5'd1, 32'hffff_0000, 4'hf);
    bus_wr(5'd2, 32'h0fff_0000, 4'hf);

    // Silent channel 3 -> timeout, raw kept
    silent = 5'h14; silent_en = 1'b1;
    run_scans(4, 16'h0000);
    silent_en = 1'b0;
    bus_rd("status_tmo", 5'd1, 32'h0000_0002);
    bus_rd("data3_tmo", 5'd11, 32'h0800_0800);
    bus_rd("data4_tmo", 5'd12, 32'h0800_0800);
    bus_wr(5'd1, 32'h0000_0002, 4'h1);
    bus_rd("status_tmo_clr", 5'd1, 32'h0000_0000);

    // Disable while in WAIT
    resp[0] = 16'h5550;
    exp_addr_q.push_back(7'h00);
    bus_wr(5'd0, 32'h0000_0001, 4'hf);
    wait_addr_drain(100);
    bus_wr(5'd0, 32'h0000_0000, 4'hf);
    repeat (100) @(negedge clk);
    bus_rd("status_stop", 5'd1, 32'h0000_0000);
    bus_rd("data0_stop", 5'd8, 32'h0555_0800);
    resp[0] = 16'h1000;
    run_scans(4, 16'h0000);
    bus_rd("data0_restart", 5'd8, 32'h0100_0100);
    check_val("temp_restart", 32'(device_temp), 32'h100);

    // Read hold with rdy low
    @(negedge clk);
    bus_if.adr = {5'd2, 2'b00}; bus_if.cs = 1'b1; bus_if.re = 1'b1; bus_if.rdy = 1'b1;
    exp_rd_q.push_back(32'h0fff_0000);
    @(negedge clk);
    check_val("rd_thresh", bus_if.dr, exp_rd_q.pop_front());
    bus_if.adr = {5'd8, 2'b00}; bus_if.rdy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      exp_rd_q.push_back(32'h0fff_0000);
      @(negedge clk);
      check_val("rd_hold", bus_if.dr, exp_rd_q.pop_front());
    end
    bus_if.rdy = 1'b1;
    exp_rd_q.push_back(32'h0100_0100);
    @(negedge clk);
    check_val("rd_after_hold", bus_if.dr, exp_rd_q.pop_front());
    bus_if.cs = 1'b0;
    exp_rd_q.push_back(32'h0000_0000);
    @(negedge clk);
    check_val("rd_nocs", bus_if.dr, exp_rd_q.pop_front());
    bus_if.re = 1'b0;
    bus_rd("rd_w30", 5'd30, 32'h0000_0000);
`ifndef RV_ADCSEQ_MINMAX_EN
    bus_rd("rd_w24", 5'd24, 32'h0000_0000);
`endif

    // Byte-lane writes
    bus_wr(5'd2, 32'hffff_ffff, 4'b0001);
    bus_rd("thresh_lane0", 5'd2, 32'h0fff_00ff);
    bus_wr(5'd2, 32'h0000_0000, 4'b1000);
    bus_rd("thresh_lane3", 5'd2, 32'h00ff_00ff);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rv_adcseq.md
Name: rv_adcseq

Overview:
- Parametrised successor to the XADC capture interface: bus-mapped DRP sequencer that actively polls N XADC channels round-robin over DRP, instead of passively capturing on EOC.
- Per-channel power-of-two averaging, latest-raw readback, global hi/lo threshold alarms with sticky flags, maskable level IRQ, averaged temperature output for the MIG.
- Sits on the rv_core data bus and drives the XADC IP DRP port directly. Single clock domain: XADC dclk is tied to clk.

Parameters:
- NCH, 7, number of polled channels (1..16)
- CH_ADDR, {5'h1a,5'h19,5'h15,5'h14,5'h12,5'h11,5'h00}, packed 5*NCH-bit DRP channel address list; entry i at bits [5i+4:5i]
- AVG_LOG2, 2, averaging depth = 2**AVG_LOG2 scans (0..6)
- TIMEOUT, 63, cycles to wait for drp_drdy before abandoning a read

Ports:
- clk  in  1  bus and DRP clock
- xreset  in  1  asynchronous active-low reset
- adr  in  7  byte address; word index = adr[6:2]
- cs  in  1  block select
- rdy  in  1  bus advance strobe
- we  in  4  byte write enables
- re  in  1  read enable
- dw  in  32  write data
- dr  out  32  read data
- drp_den  out  1  DRP enable pulse
- drp_daddr  out  7  DRP address = {2'b00, CH_ADDR[i]}
- drp_drdy  in  1  DRP read done
- drp_do  in  16  DRP read data; sample = drp_do[15:4]
- device_temp  out  12  averaged channel 0 value
- irq  out  1  level interrupt

Behaviour:
- Reset values: dr=0, drp_den=0, drp_daddr=0, device_temp=0, irq=0. All registers, accumulators, raw/avg values and flags = 0. FSM = IDLE.
- Registers (32-bit words):
  - W0 CTRL rw: [0] enable; [31:16] alarm mask.
  - W1 STATUS: [0] busy (ro); [1] timeout sticky (W1C); [31:16] per-channel alarm sticky (W1C).
  - W2 THRESH rw: [11:0] lo; [27:16] hi. Reset: hi=12'hfff, lo=0.
  - W8+i DATA ro: [11:0] average; [27:16] latest raw.
  - Unmapped words read 0.
- Bus timing:
  - Write commits when cs && rdy && we!=0, per byte lane.
  - Read: when rdy, dr <= (cs && re) ? word : 0. One-cycle latency; dr holds its value while rdy=0.
- FSM:
  - IDLE: if enable, clear idx, go REQ.
  - REQ: drp_den=1 for exactly 1 cycle, drp_daddr=CH_ADDR[idx]. Go WAIT.
  - WAIT: on drp_drdy, raw[idx] <= drp_do[15:4], go ACC. If TIMEOUT cycles pass without drdy, set timeout sticky, reuse the old raw[idx], go ACC.
  - ACC: acc[idx] += raw[idx]. acc width = 12+AVG_LOG2.
  - NEXT: if idx==NCH-1, idx<=0 and scan_cnt++, else idx++. When scan_cnt wraps at 2**AVG_LOG2: avg[i] <= acc[i]>>AVG_LOG2 for all i, acc cleared, alarm compare runs. Then go REQ if enable, else IDLE.
- Alarm:
  - On average update, set alarm[i] if avg > hi or avg < lo. Strict compares; equality does not alarm.
  - If set and W1C hit the same cycle, set wins.
- irq = |(alarm & mask), registered; one cycle after the flag or mask changes.
- device_temp updates with avg[0] on each average update.
- Enable cleared mid-scan: the outstanding DRP transaction completes (or times out), then IDLE. Accumulators, idx and scan_cnt are cleared; avg and raw are retained.
- busy = FSM != IDLE.
- drp_drdy outside WAIT is ignored.
- AVG_LOG2=0: every scan updates avg directly.

Optional Feature:
- RV_ADCSEQ_MINMAX_EN.
- Defined: words W24+i read {max[27:16], min[11:0]} of averaged values per channel. min resets to 12'hfff, max to 0; both update on each average update. Writing CTRL[1]=1 re-arms min/max to their reset values; the bit is self-clearing and reads 0.
- Undefined: W24.. read 0, CTRL[1] is ignored, no min/max storage is synthesised.

Test Plan:
- Reset, enable=1, DRP model returns drdy 3 cycles after den with drp_do=16'h8000 on all channels -> daddr sequence 00,11,12,14,15,19,1a repeats; after 4 scans DATA[i]=0x08000800, device_temp=12'h800.
- Channel 0 returns 0x1000,0x2000,0x3000,0x4000 over four scans (AVG_LOG2=2) -> avg[0]=12'h280, raw[0]=12'h400.
- THRESH hi=0x700, mask[16]=1, ch0 average 0x800 -> alarm bit 16 set, irq=1 one cycle later. W1C STATUS bit16 while the condition persists -> bit re-sets at the next average update.
- DRP model never asserts drdy for channel 3 -> WAIT exits after 63 cycles, timeout sticky=1, scan continues at channel 4, DATA[3] raw is unchanged.
- Clear enable while in WAIT -> drdy still accepted, FSM returns to IDLE, busy=0, no further den pulses; re-enable restarts at idx 0 with cleared accumulators.
- Read W8 with rdy held low for 2 cycles -> dr holds its previous value, then presents DATA[0] one cycle after rdy goes high; reads of W30 (unmapped without MINMAX) return 0.
